alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU (operands A, B, 3-bit select; outputs Result and Cout).
- Accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures Result/Cout, and returns them to the owning requester over a valid/ready response channel.
- Sits between the front-end requesters and the ALU instance; the ALU itself stays combinational and external.

Parameters:
- DATA_W, 8, operand/result width.
- SEL_W, 3, ALU operation-select width; passed through opaquely, no decoding.
- CNT_W, 8, width of the grant counters (optional feature only).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  input  1  operation request from requester 0 / 1.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_sel / req1_sel  input  SEL_W  ALU operation select.
- req0_a / req1_a  input  DATA_W  operand A.
- req0_b / req1_b  input  DATA_W  operand B.
- rsp0_valid / rsp1_valid  output  1  result available for requester 0 / 1.
- rsp0_ready / rsp1_ready  input  1  requester consumes its result.
- rsp_result  output  DATA_W  captured ALU Result, shared by both response channels.
- rsp_cout  output  1  captured ALU Cout.
- alu_a  output  DATA_W  to ALU A.
- alu_b  output  DATA_W  to ALU B.
- alu_sel  output  SEL_W  to ALU sel.
- alu_result  input  DATA_W  from ALU Result.
- alu_cout  input  1  from ALU Cout.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State IDLE; all req*_ready and rsp*_valid low; busy low.
  - rsp_result 0, rsp_cout 0, alu_a/alu_b/alu_sel 0.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is chosen combinationally.
    - Only one valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins.
  - reqN_ready is asserted combinationally for the winner only; at most one ready is high per cycle.
  - On handshake (valid && ready): latch sel/a/b into the operand registers, record owner, go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a/alu_b/alu_sel come directly from the operand registers; no combinational path from req* to alu*.
  - Capture alu_result/alu_cout into rsp_result/rsp_cout; go to RESP.
- RESP:
  - rsp{owner}_valid high; the other rsp*_valid stays low.
  - Hold the valid and the data stable until rsp{owner}_ready.
  - On that handshake: last_grant = owner, go to IDLE.
- Latency and throughput:
  - Handshake at edge T → rsp_valid high after edge T+2.
  - Minimum 3 cycles per operation. No ready is issued in EXEC or RESP.
- Operand registers and alu_* hold their last values between operations.
- Requesters must hold valid and payload stable until ready; a request dropped before ready is simply not serviced.
- rsp*_ready while that rsp*_valid is low has no effect.
- Reset mid-operation: the in-flight result is discarded; rsp*_valid falls immediately.
- Arithmetic: no modification of ALU outputs. Width extension of operands is the requester's responsibility.

Optional Feature:
- Macro ALU_ARBITER_STATS_EN.
- Defined:
  - Adds outputs gnt0_cnt and gnt1_cnt (CNT_W each).
  - Each counter increments on its requester's request handshake and saturates at 2^CNT_W−1 (255 by default).
  - Both counters clear on rst.
- Undefined:
  - Ports and counters are absent.
  - All other behaviour is identical.

Test Plan:
- Bench ALU model for all scenarios: alu_result = (alu_a + alu_b) mod 256, alu_cout = carry.
- Reset values: assert rst for 2 cycles → all outputs 0, busy 0, no ready high while both valids are low.
- Single request: req0 {sel=0, a=0x05, b=0x03}, rsp0_ready held high → req0_ready at T; rsp0_valid after T+2 with rsp_result=0x08, rsp_cout=0; back in IDLE one cycle later.
- Contention and fairness: req0 and req1 valid continuously with rsp*_ready=1:
  - Grants alternate 0,1,0,1.
  - req1 {a=0xFF, b=0x02} → rsp_result=0x01, rsp_cout=1.
- Response backpressure: rsp0_ready held low for 5 cycles → rsp0_valid and rsp_result stay stable; req1_ready stays low throughout; req1 is granted in the cycle after rsp0_ready rises.
- Reset mid-op: assert rst during EXEC → rsp*_valid never rises; state IDLE; the next request (req0 and req1 both valid) grants req0.
- With ALU_ARBITER_STATS_EN: 300 back-to-back req0 operations → gnt0_cnt=255 (saturated), gnt1_cnt=0; after rst both read 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin sequencer in front of a shared combinational ALU.
// Defining ALU_ARBITER_STATS_EN adds saturating per-requester grant counters (gnt0_cnt, gnt1_cnt).
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_sel,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_cout,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    output logic              busy
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0]  gnt0_cnt,
    output logic [CNT_W-1:0]  gnt1_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_last;
    logic                r_owner;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_result;
    logic                r_cout;

    logic                w_win0;
    logic                w_win1;
    logic                w_hs0;
    logic                w_hs1;
    logic                w_req_hs;
    logic                w_rsp_hs;

    // Contention goes to whichever requester was not served last.
    assign w_win0 = req0_valid && (!req1_valid || r_last);
    assign w_win1 = req1_valid && (!req0_valid || !r_last);

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst so nothing is offered while reset is held.
                req0_ready = w_win0 && !rst;
                req1_ready = w_win1 && !rst;
                if ((w_win0 || w_win1) && !rst) begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = !r_owner;
                rsp1_valid = r_owner;
                w_rsp_hs   = r_owner ? rsp1_ready : rsp0_ready;
                if (w_rsp_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_hs0    = req0_valid && req0_ready;
    assign w_hs1    = req1_valid && req1_ready;
    assign w_req_hs = w_hs0 || w_hs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
        end else begin
            if (w_req_hs) begin
                r_owner <= w_hs1;
                r_a     <= w_hs1 ? req1_a   : req0_a;
                r_b     <= w_hs1 ? req1_b   : req0_b;
                r_sel   <= w_hs1 ? req1_sel : req0_sel;
            end
            if (w_rsp_hs) begin
                r_last <= r_owner;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_result <= alu_result;
            r_cout   <= alu_cout;
        end
    end

    // The ALU only ever sees registered operands.
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_sel    = r_sel;
    assign rsp_result = r_result;
    assign rsp_cout   = r_cout;
    assign busy       = (r_state != IDLE);

`ifdef ALU_ARBITER_STATS_EN
    logic [CNT_W-1:0] r_gnt0_cnt;
    logic [CNT_W-1:0] r_gnt1_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (w_hs0 && (r_gnt0_cnt != '1)) begin
                r_gnt0_cnt <= r_gnt0_cnt + 1'b1;
            end
            if (w_hs1 && (r_gnt1_cnt != '1)) begin
                r_gnt1_cnt <= r_gnt1_cnt + 1'b1;
            end
        end
    end

    assign gnt0_cnt = r_gnt0_cnt;
    assign gnt1_cnt = r_gnt1_cnt;
`else
    // Counter width only matters with the statistics build; still reject nonsense values.
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("alu_arbiter: CNT_W must be at least 1");
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized + directed bench with a queue scoreboard and a cycle-level reference model.
// Build with ALU_ARBITER_STATS_EN defined to also exercise the grant counters.
module tb_alu_arbiter;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [SW-1:0] req0_sel = '0, req1_sel = '0;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DW-1:0] rsp_result;
    logic          rsp_cout;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [SW-1:0] alu_sel;
    logic          alu_cout;
    logic          busy;
`ifdef ALU_ARBITER_STATS_EN
    logic [CW-1:0] gnt0_cnt, gnt1_cnt;
`endif

    alu_arbiter #(.DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .busy(busy)
`ifdef ALU_ARBITER_STATS_EN
        , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt)
`endif
    );

    // Stand-in ALU: plain 8-bit add with carry out.
    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight at a time, round-robin on last served.
    typedef struct {
        logic       own;
        logic [7:0] res;
        logic       cout;
        int         due;
    } exp_t;

    exp_t q[$];
    logic m_last = 1'b1;
    int   m_g0 = 0, m_g1 = 0;
    logic e_r0, e_r1, e_v0, e_v1, m_idle;
    logic acc0 = 1'b0, acc1 = 1'b0;

    function automatic exp_t make_exp(input logic own, input logic [7:0] a, input logic [7:0] b,
                                      input int due);
        exp_t e;
        int   s;
        s      = int'(a) + int'(b);
        e.own  = own;
        e.res  = 8'(s % 256);
        e.cout = (s > 255);
        e.due  = due;
        return e;
    endfunction

    always @(negedge clk) begin
        acc0 <= req0_valid && req0_ready;
        acc1 <= req1_valid && req1_ready;
        if (rst) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            chk("rst_alu_ops", {alu_a, alu_b, alu_sel}, 0);
            q.delete();
            m_last = 1'b1;
            m_g0   = 0;
            m_g1   = 0;
        end else begin
            m_idle = (q.size() == 0);
            e_r0   = m_idle && req0_valid && (!req1_valid || m_last);
            e_r1   = m_idle && req1_valid && (!req0_valid || !m_last);
            e_v0   = !m_idle && (cyc >= q[0].due) && !q[0].own;
            e_v1   = !m_idle && (cyc >= q[0].due) && q[0].own;
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("rsp0_valid", rsp0_valid, e_v0);
            chk("rsp1_valid", rsp1_valid, e_v1);
            chk("busy", busy, !m_idle);
            if (e_v0 || e_v1) begin
                chk("rsp_result", rsp_result, q[0].res);
                chk("rsp_cout", rsp_cout, q[0].cout);
            end
            if ((e_v0 && rsp0_ready) || (e_v1 && rsp1_ready)) begin
                m_last = q[0].own;
                void'(q.pop_front());
            end else if (e_r0) begin
                q.push_back(make_exp(1'b0, req0_a, req0_b, cyc + 2));
                if (m_g0 < 255) m_g0++;
            end else if (e_r1) begin
                q.push_back(make_exp(1'b1, req1_a, req1_b, cyc + 2));
                if (m_g1 < 255) m_g1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int who, input logic v, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b);
        if (who == 0) begin
            req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
        end
    endtask

    // Present a request and hold it until accepted; returns in the cycle after the handshake.
    task automatic send(input int who, input logic [2:0] s, input logic [7:0] a,
                        input logic [7:0] b, input int budget);
        int ok = 0;
        drive(who, 1'b1, s, a, b);
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((who == 0 && acc0) || (who == 1 && acc1)) begin
                ok = 1;
                break;
            end
        end
        chk("accept_wait", ok, 1);
        if (who == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    int grants[$];
    int nacc;

    initial begin
        // Reset for two cycles with no requests.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Single request from requester 0.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        send(0, 3'd0, 8'h05, 8'h03, 10);
        chk("single_exec_busy", busy, 1);
        tick();
        chk("single_rsp0_valid", rsp0_valid, 1);
        chk("single_result", rsp_result, 8'h08);
        chk("single_cout", rsp_cout, 0);
        tick();
        chk("single_idle", busy, 0);

        // Carry case from requester 1.
        send(1, 3'd2, 8'hFF, 8'h02, 10);
        tick();
        chk("carry_rsp1_valid", rsp1_valid, 1);
        chk("carry_result", rsp_result, 8'h01);
        chk("carry_cout", rsp_cout, 1);
        tick();

        // Contention: both valid continuously.
        drive(0, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
        drive(1, 1'b1, 3'd1, 8'hFF, 8'h02);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (acc0) begin
                grants.push_back(0);
                drive(0, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
            end
            if (acc1) grants.push_back(1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("contention_grants", grants.size() >= 4, 1);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("grant_order", grants[i], i % 2);
        repeat (4) tick();

        // Response backpressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0;
        send(0, 3'd3, 8'h40, 8'h30, 10);
        drive(1, 1'b1, 3'd4, 8'h11, 8'h22);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_result", rsp_result, 8'h70);
            chk("bp_req1_ready", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        chk("bp_req1_granted", req1_ready, 1);
        tick();
        chk("bp_req1_acc", acc1, 1);
        req1_valid = 1'b0;
        repeat (4) tick();

        // Reset while the operation is executing.
        send(0, 3'd0, 8'h12, 8'h34, 10);
        rst = 1'b1;
        drive(0, 1'b1, 3'd0, 8'h01, 8'h01);
        drive(1, 1'b1, 3'd0, 8'h02, 8'h02);
        #1;
        chk("midrst_rsp0_valid", rsp0_valid, 0);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_req0_ready", req0_ready, 1);
        chk("midrst_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 20 && !acc1; i++) tick();
        req1_valid = 1'b0;
        repeat (4) tick();

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || acc0)
                drive(0, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            if (!req1_valid || acc1)
                drive(1, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        repeat (10) tick();
        chk("drain_empty", q.size(), 0);

`ifdef ALU_ARBITER_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        nacc = 0;
        drive(0, 1'b1, 3'd0, 8'h01, 8'h02);
        for (int i = 0; i < 1200 && nacc < 300; i++) begin
            tick();
            if (acc0) nacc++;
        end
        req0_valid = 1'b0;
        chk("stats_ops", nacc, 300);
        repeat (4) tick();
        chk("gnt0_sat", gnt0_cnt, 255);
        chk("gnt1_zero", gnt1_cnt, 0);
        chk("gnt0_model", gnt0_cnt, m_g0);
        chk("gnt1_model", gnt1_cnt, m_g1);
        rst = 1'b1;
        #1;
        chk("gnt0_rst", gnt0_cnt, 0);
        chk("gnt1_rst", gnt1_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
